// File: rtl/gate_response_checker_if.sv
// Stimulus/response bundle between a gate-level DUT driver and gate_response_checker.
// GATE_CHK_FIRST_FAIL_EN adds the first-failure capture signals.
interface gate_response_checker_if #(
    parameter int CW = 8
);
    logic          en;
    logic          stim;
    logic          dut_out;
    logic          busy;
    logic          valid;
    logic          last_ok;
    logic          err;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
`ifdef GATE_CHK_FIRST_FAIL_EN
    logic          first_fail_stim;
    logic [CW-1:0] first_fail_idx;
    logic          first_fail_vld;

    modport master (
        output en, stim, dut_out,
        input  busy, valid, last_ok, err, pass_cnt, fail_cnt,
        input  first_fail_stim, first_fail_idx, first_fail_vld
    );

    modport slave (
        input  en, stim, dut_out,
        output busy, valid, last_ok, err, pass_cnt, fail_cnt,
        output first_fail_stim, first_fail_idx, first_fail_vld
    );
`else
    modport master (
        output en, stim, dut_out,
        input  busy, valid, last_ok, err, pass_cnt, fail_cnt
    );

    modport slave (
        input  en, stim, dut_out,
        output busy, valid, last_ok, err, pass_cnt, fail_cnt
    );
`endif
endinterface

// File: rtl/gate_response_checker.sv
// Response monitor: after each stimulus change, waits SETTLE cycles, samples the DUT output and counts pass/fail.
// Optional first-failure capture is enabled by defining GATE_CHK_FIRST_FAIL_EN.
module gate_response_checker #(
    parameter int SETTLE = 4,
    parameter bit INVERT = 1'b1,
    parameter int CW     = 8
) (
    input  logic clk,
    input  logic rst,
    gate_response_checker_if.slave chk
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    localparam logic [7:0]    CNT_LOAD = 8'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t        state_q, state_nxt;
    logic [7:0]    cnt_q, cnt_nxt;
    logic          exp_q, exp_nxt;
    logic          stim_q;
    logic          change;
    logic          cmp_fire;
    logic          match;

    logic          valid_q;
    logic          last_ok_q;
    logic          err_q;
    logic [CW-1:0] pass_q;
    logic [CW-1:0] fail_q;

    assign change = (chk.stim != stim_q);
    assign match  = (chk.dut_out == exp_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            exp_q   <= 1'b0;
            stim_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            exp_q   <= exp_nxt;
            stim_q  <= chk.stim;
        end
    end

    // A fresh change always wins over a pending sample; en low aborts without counting.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        exp_nxt   = exp_q;
        cmp_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (chk.en && change) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = CNT_LOAD;
                    exp_nxt   = chk.stim ^ INVERT;
                end
            end
            ST_SETTLE: begin
                if (!chk.en) begin
                    state_nxt = ST_IDLE;
                end else if (change) begin
                    cnt_nxt = CNT_LOAD;
                    exp_nxt = chk.stim ^ INVERT;
                end else if (cnt_q != 8'd0) begin
                    cnt_nxt = cnt_q - 8'd1;
                end else begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (!chk.en) begin
                    state_nxt = ST_IDLE;
                end else if (change) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = CNT_LOAD;
                    exp_nxt   = chk.stim ^ INVERT;
                end else begin
                    state_nxt = ST_IDLE;
                    cmp_fire  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            last_ok_q <= 1'b0;
            err_q     <= 1'b0;
            pass_q    <= '0;
            fail_q    <= '0;
        end else begin
            valid_q <= cmp_fire;
            if (cmp_fire) begin
                last_ok_q <= match;
                if (match) begin
                    if (pass_q != CNT_MAX)
                        pass_q <= pass_q + 1'b1;
                end else begin
                    err_q <= 1'b1;
                    if (fail_q != CNT_MAX)
                        fail_q <= fail_q + 1'b1;
                end
            end
        end
    end

`ifdef GATE_CHK_FIRST_FAIL_EN
    logic          ff_stim_q;
    logic [CW-1:0] ff_idx_q;
    logic          ff_vld_q;

    // exp was derived from stim, so the checked stim is recovered from exp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_stim_q <= 1'b0;
            ff_idx_q  <= '0;
            ff_vld_q  <= 1'b0;
        end else if (cmp_fire && !match && !ff_vld_q) begin
            ff_stim_q <= exp_q ^ INVERT;
            ff_idx_q  <= pass_q + fail_q;
            ff_vld_q  <= 1'b1;
        end
    end

    assign chk.first_fail_stim = ff_stim_q;
    assign chk.first_fail_idx  = ff_idx_q;
    assign chk.first_fail_vld  = ff_vld_q;
`endif

    assign chk.busy     = (state_q != ST_IDLE);
    assign chk.valid    = valid_q;
    assign chk.last_ok  = last_ok_q;
    assign chk.err      = err_q;
    assign chk.pass_cnt = pass_q;
    assign chk.fail_cnt = fail_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker (SETTLE=4, INVERT=1, CW=8).
// Define GATE_CHK_FIRST_FAIL_EN to also exercise the first-failure capture.
module tb_gate_response_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    gate_response_checker_if #(.CW(8)) bus ();

    gate_response_checker #(
        .SETTLE(4),
        .INVERT(1'b1),
        .CW(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .chk(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mode 0: correct inverter, 1: stuck at 1, 2: stuck at 0
    task automatic drive(input logic s, input int mode);
        bus.stim = s;
        case (mode)
            0:       bus.dut_out = ~s;
            1:       bus.dut_out = 1'b1;
            default: bus.dut_out = 1'b0;
        endcase
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        bus.en = 1'b1;
        drive(1'b0, 0);
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        bus.en = 1'b1;
        drive(1'b0, 0);
        #1;
        n_cmp++; if (bus.busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        n_cmp++; if (bus.valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.valid); end
        n_cmp++; if (bus.last_ok !== 1'b0)  begin n_fail++; $display("FAIL reset_last_ok got %0b want 0", bus.last_ok); end
        n_cmp++; if (bus.err !== 1'b0)      begin n_fail++; $display("FAIL reset_err got %0b want 0", bus.err); end
        n_cmp++; if (bus.pass_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_pass got %0d want 0", bus.pass_cnt); end
        n_cmp++; if (bus.fail_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_fail got %0d want 0", bus.fail_cnt); end
`ifdef GATE_CHK_FIRST_FAIL_EN
        n_cmp++; if (bus.first_fail_vld !== 1'b0) begin n_fail++; $display("FAIL reset_ff_vld got %0b want 0", bus.first_fail_vld); end
`endif
        do_reset();
    endtask

    task automatic test_inverter();
        do_reset();
        drive(1'b1, 0);
        step(1);
        n_cmp++; if (bus.busy !== 1'b1)  begin n_fail++; $display("FAIL inv_busy_E got %0b want 1", bus.busy); end
        n_cmp++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL inv_valid_E got %0b want 0", bus.valid); end
        step(4);
        n_cmp++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL inv_valid_E4 got %0b want 0", bus.valid); end
        n_cmp++; if (bus.busy !== 1'b1)  begin n_fail++; $display("FAIL inv_busy_E4 got %0b want 1", bus.busy); end
        step(1);
        n_cmp++; if (bus.valid !== 1'b1)    begin n_fail++; $display("FAIL inv_valid_E5 got %0b want 1", bus.valid); end
        n_cmp++; if (bus.last_ok !== 1'b1)  begin n_fail++; $display("FAIL inv_last_ok got %0b want 1", bus.last_ok); end
        n_cmp++; if (bus.pass_cnt !== 8'd1) begin n_fail++; $display("FAIL inv_pass got %0d want 1", bus.pass_cnt); end
        n_cmp++; if (bus.fail_cnt !== 8'd0) begin n_fail++; $display("FAIL inv_fail got %0d want 0", bus.fail_cnt); end
        n_cmp++; if (bus.err !== 1'b0)      begin n_fail++; $display("FAIL inv_err got %0b want 0", bus.err); end
        step(1);
        n_cmp++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL inv_valid_E6 got %0b want 0", bus.valid); end
        n_cmp++; if (bus.busy !== 1'b0)  begin n_fail++; $display("FAIL inv_busy_E6 got %0b want 0", bus.busy); end
        step(3);
    endtask

    task automatic test_fault();
        do_reset();
        drive(1'b1, 1);
        step(6);
        n_cmp++; if (bus.valid !== 1'b1)    begin n_fail++; $display("FAIL flt_valid got %0b want 1", bus.valid); end
        n_cmp++; if (bus.last_ok !== 1'b0)  begin n_fail++; $display("FAIL flt_last_ok got %0b want 0", bus.last_ok); end
        n_cmp++; if (bus.fail_cnt !== 8'd1) begin n_fail++; $display("FAIL flt_fail got %0d want 1", bus.fail_cnt); end
        n_cmp++; if (bus.pass_cnt !== 8'd0) begin n_fail++; $display("FAIL flt_pass got %0d want 0", bus.pass_cnt); end
        n_cmp++; if (bus.err !== 1'b1)      begin n_fail++; $display("FAIL flt_err got %0b want 1", bus.err); end
        step(3);
        drive(1'b0, 0);
        step(6);
        n_cmp++; if (bus.valid !== 1'b1)    begin n_fail++; $display("FAIL flt2_valid got %0b want 1", bus.valid); end
        n_cmp++; if (bus.last_ok !== 1'b1)  begin n_fail++; $display("FAIL flt2_last_ok got %0b want 1", bus.last_ok); end
        n_cmp++; if (bus.pass_cnt !== 8'd1) begin n_fail++; $display("FAIL flt2_pass got %0d want 1", bus.pass_cnt); end
        n_cmp++; if (bus.fail_cnt !== 8'd1) begin n_fail++; $display("FAIL flt2_fail got %0d want 1", bus.fail_cnt); end
        n_cmp++; if (bus.err !== 1'b1)      begin n_fail++; $display("FAIL flt2_err_sticky got %0b want 1", bus.err); end
        step(2);
    endtask

    task automatic test_rechange();
        logic want;
        do_reset();
        drive(1'b1, 0);
        step(2);
        drive(1'b0, 0);
        for (int k = 2; k <= 10; k++) begin
            step(1);
            want = (k == 7);
            n_cmp++; if (bus.valid !== want) begin n_fail++; $display("FAIL rechg_valid_E%0d got %0b want %0b", k, bus.valid, want); end
        end
        n_cmp++; if (bus.pass_cnt !== 8'd1) begin n_fail++; $display("FAIL rechg_pass got %0d want 1", bus.pass_cnt); end
        n_cmp++; if (bus.fail_cnt !== 8'd0) begin n_fail++; $display("FAIL rechg_fail got %0d want 0", bus.fail_cnt); end
        n_cmp++; if (bus.last_ok !== 1'b1)  begin n_fail++; $display("FAIL rechg_last_ok got %0b want 1", bus.last_ok); end
    endtask

    task automatic test_change_on_sample();
        do_reset();
        drive(1'b1, 0);
        step(5);
        drive(1'b0, 0);
        step(1);
        n_cmp++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL smpchg_valid_E5 got %0b want 0", bus.valid); end
        n_cmp++; if (bus.busy !== 1'b1)  begin n_fail++; $display("FAIL smpchg_busy_E5 got %0b want 1", bus.busy); end
        step(4);
        n_cmp++; if (bus.valid !== 1'b0)    begin n_fail++; $display("FAIL smpchg_valid_E9 got %0b want 0", bus.valid); end
        n_cmp++; if (bus.pass_cnt !== 8'd0) begin n_fail++; $display("FAIL smpchg_pass_E9 got %0d want 0", bus.pass_cnt); end
        step(1);
        n_cmp++; if (bus.valid !== 1'b1)    begin n_fail++; $display("FAIL smpchg_valid_E10 got %0b want 1", bus.valid); end
        n_cmp++; if (bus.pass_cnt !== 8'd1) begin n_fail++; $display("FAIL smpchg_pass got %0d want 1", bus.pass_cnt); end
        step(2);
    endtask

    task automatic test_enable();
        int nv;
        do_reset();
        drive(1'b1, 0);
        step(1);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL en_busy_E got %0b want 1", bus.busy); end
        step(2);
        bus.en = 1'b0;
        step(1);
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL en_busy_E3 got %0b want 0", bus.busy); end
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            if (bus.valid === 1'b1) nv++;
        end
        n_cmp++; if (nv !== 0)              begin n_fail++; $display("FAIL en_no_valid got %0d want 0", nv); end
        n_cmp++; if (bus.pass_cnt !== 8'd0) begin n_fail++; $display("FAIL en_pass got %0d want 0", bus.pass_cnt); end
        n_cmp++; if (bus.fail_cnt !== 8'd0) begin n_fail++; $display("FAIL en_fail got %0d want 0", bus.fail_cnt); end
        drive(1'b0, 0);
        step(3);
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL en_idle_ignore got %0b want 0", bus.busy); end
        bus.en = 1'b1;
        drive(1'b1, 0);
        step(1);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL en_rearm_busy got %0b want 1", bus.busy); end
        step(5);
        n_cmp++; if (bus.valid !== 1'b1)    begin n_fail++; $display("FAIL en_rearm_valid got %0b want 1", bus.valid); end
        n_cmp++; if (bus.pass_cnt !== 8'd1) begin n_fail++; $display("FAIL en_rearm_pass got %0d want 1", bus.pass_cnt); end
        step(2);
    endtask

    task automatic test_saturation();
        logic s;
        do_reset();
        s = 1'b0;
        for (int i = 1; i <= 260; i++) begin
            s = ~s;
            drive(s, 0);
            step(7);
            if (i == 255) begin
                n_cmp++; if (bus.pass_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_pass_255 got %0d want 255", bus.pass_cnt); end
            end
        end
        n_cmp++; if (bus.pass_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_pass_260 got %0d want 255", bus.pass_cnt); end
        n_cmp++; if (bus.fail_cnt !== 8'd0)   begin n_fail++; $display("FAIL sat_fail got %0d want 0", bus.fail_cnt); end
        n_cmp++; if (bus.err !== 1'b0)        begin n_fail++; $display("FAIL sat_err got %0b want 0", bus.err); end
        s = ~s;
        drive(s, 0);
        step(2);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL sat_busy_pre_rst got %0b want 1", bus.busy); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.busy !== 1'b0)     begin n_fail++; $display("FAIL arst_busy got %0b want 0", bus.busy); end
        n_cmp++; if (bus.last_ok !== 1'b0)  begin n_fail++; $display("FAIL arst_last_ok got %0b want 0", bus.last_ok); end
        n_cmp++; if (bus.pass_cnt !== 8'd0) begin n_fail++; $display("FAIL arst_pass got %0d want 0", bus.pass_cnt); end
        n_cmp++; if (bus.valid !== 1'b0)    begin n_fail++; $display("FAIL arst_valid got %0b want 0", bus.valid); end
        step(2);
        drive(1'b0, 0);
        rst = 1'b0;
        step(8);
        n_cmp++; if (bus.pass_cnt !== 8'd0) begin n_fail++; $display("FAIL arst_no_count got %0d want 0", bus.pass_cnt); end
    endtask

`ifdef GATE_CHK_FIRST_FAIL_EN
    task automatic test_first_fail();
        do_reset();
        drive(1'b1, 0); step(7);
        drive(1'b0, 0); step(7);
        drive(1'b1, 0); step(7);
        n_cmp++; if (bus.first_fail_vld !== 1'b0) begin n_fail++; $display("FAIL ff_vld_pre got %0b want 0", bus.first_fail_vld); end
        drive(1'b0, 2); step(7);
        n_cmp++; if (bus.first_fail_vld !== 1'b1)  begin n_fail++; $display("FAIL ff_vld got %0b want 1", bus.first_fail_vld); end
        n_cmp++; if (bus.first_fail_idx !== 8'd3)  begin n_fail++; $display("FAIL ff_idx got %0d want 3", bus.first_fail_idx); end
        n_cmp++; if (bus.first_fail_stim !== 1'b0) begin n_fail++; $display("FAIL ff_stim got %0b want 0", bus.first_fail_stim); end
        drive(1'b1, 1); step(7);
        n_cmp++; if (bus.fail_cnt !== 8'd2)        begin n_fail++; $display("FAIL ff_fail2 got %0d want 2", bus.fail_cnt); end
        n_cmp++; if (bus.first_fail_idx !== 8'd3)  begin n_fail++; $display("FAIL ff_idx_frozen got %0d want 3", bus.first_fail_idx); end
        n_cmp++; if (bus.first_fail_stim !== 1'b0) begin n_fail++; $display("FAIL ff_stim_frozen got %0b want 0", bus.first_fail_stim); end
        n_cmp++; if (bus.first_fail_vld !== 1'b1)  begin n_fail++; $display("FAIL ff_vld_frozen got %0b want 1", bus.first_fail_vld); end
    endtask
`endif

    initial begin
        test_reset();
        test_inverter();
        test_fault();
        test_rechange();
        test_change_on_sample();
        test_enable();
        test_saturation();
`ifdef GATE_CHK_FIRST_FAIL_EN
        test_first_fail();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
